afifo_wr_arb: RTL and testbench

//  Round-robin, burst-granular arbiter sharing the write port of one afifo
//  (OFLOW="IGNORE") among N requesters in the wclk domain. Each grant lasts

---
 rtl/afifo_wr_arb_if.sv | 24 ++
 rtl/afifo_wr_arb.sv | 113 +++++++++++
 tb/tb_afifo_wr_arb.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/afifo_wr_arb_if.sv
// Producer-side bus of afifo_wr_arb: per-requester request/data/last/ack plus the afifo write port.
// master = producers and afifo (drive requests and wfull), slave = the arbiter.
interface afifo_wr_arb_if #(
  parameter int N     = 4,
  parameter int WIDTH = 8
);
  logic [N-1:0]       req;
  logic [N*WIDTH-1:0] reqdata;
  logic [N-1:0]       reqlast;
  logic [N-1:0]       ack;
  logic [WIDTH-1:0]   wdata;
  logic               wstore;
  logic               wfull;

  modport master (
    output req, reqdata, reqlast, wfull,
    input  ack, wdata, wstore
  );

  modport slave (
    input  req, reqdata, reqlast, wfull,
    output ack, wdata, wstore
  );
endinterface

// File: rtl/afifo_wr_arb.sv
// Round-robin, burst-granular arbiter for one afifo write port (wclk domain).
// Define AFIFO_ARB_HDR_EN to prefix every burst with a header word carrying the owner index.
module afifo_wr_arb #(
  parameter int N        = 4,
  parameter int WIDTH    = 8,
  parameter int IW       = 2,
  parameter int MAXBURST = 16
) (
  input  logic          wclk,
  input  logic          wreset,
  afifo_wr_arb_if.slave bus,
  output logic          busy,
  output logic [IW-1:0] owner
);
  localparam int CW = $clog2(MAXBURST) + 1;

`ifdef AFIFO_ARB_HDR_EN
  typedef enum logic [1:0] {IDLE, HDR, BURST} state_t;
`else
  typedef enum logic [1:0] {IDLE, BURST} state_t;
`endif

  state_t         state_q, state_d;
  logic [IW-1:0]  owner_q, owner_d;
  logic [IW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IW-1:0]  grant_idx;
  logic           grant_found;
  logic           owner_req, owner_last, burst_end;
  logic           wstore_c;
  logic [N-1:0]   ack_c;
  logic [WIDTH-1:0] wdata_c;

  // Scan starts just after the last holder, so the previous owner has lowest priority.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = 1; k <= N; k++) begin
      if (!grant_found && bus.req[(int'(ptr_q) + k) % N]) begin
        grant_found = 1'b1;
        grant_idx   = IW'((int'(ptr_q) + k) % N);
      end
    end
  end

  assign owner_req  = bus.req[owner_q];
  assign owner_last = bus.reqlast[owner_q];
  assign burst_end  = owner_last || (cnt_q == CW'(MAXBURST - 1));

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    cnt_d    = cnt_q;
    wstore_c = 1'b0;
    ack_c    = '0;
    wdata_c  = bus.reqdata[owner_q*WIDTH +: WIDTH];
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          owner_d = grant_idx;
          cnt_d   = '0;
`ifdef AFIFO_ARB_HDR_EN
          state_d = HDR;
`else
          state_d = BURST;
`endif
        end
      end
`ifdef AFIFO_ARB_HDR_EN
      HDR: begin
        wdata_c  = WIDTH'(owner_q);
        wstore_c = ~bus.wfull;
        if (!bus.wfull) state_d = BURST;
      end
`endif
      BURST: begin
        // A stalled or absent owner simply holds the grant; nothing advances without a store.
        wstore_c = owner_req & ~bus.wfull;
        if (wstore_c) begin
          ack_c = N'(1) << owner_q;
          cnt_d = cnt_q + CW'(1);
          if (burst_end) begin
            state_d = IDLE;
            ptr_d   = owner_q;
            cnt_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wclk) begin
    if (wreset) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= IW'(N - 1);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.wstore = wstore_c;
  assign bus.ack    = ack_c;
  assign bus.wdata  = wdata_c;
  assign busy       = (state_q != IDLE);
  assign owner      = owner_q;
endmodule

// File: tb/tb_afifo_wr_arb.sv
// Bench for afifo_wr_arb: cycle vector table for arbitration order, plus scoreboarded
// burst sequences (MAXBURST split, wfull stall, mid-burst reset).
module tb_afifo_wr_arb;
  localparam int N = 4, WIDTH = 8, IW = 2, MAXBURST = 16;
`ifdef AFIFO_ARB_HDR_EN
  localparam int H = 1;
`else
  localparam int H = 0;
`endif

  logic          wclk = 1'b0;
  logic          wreset;
  logic          busy;
  logic [IW-1:0] owner;

  afifo_wr_arb_if #(.N(N), .WIDTH(WIDTH)) bus ();

  afifo_wr_arb #(.N(N), .WIDTH(WIDTH), .IW(IW), .MAXBURST(MAXBURST)) dut (
    .wclk  (wclk),
    .wreset(wreset),
    .bus   (bus),
    .busy  (busy),
    .owner (owner)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- producer model and scoreboard ----------------
  typedef struct {
    logic [7:0] data;
    logic       hdr;
    int         src;
  } sb_t;
  sb_t sb[$];

  int   seq[N];
  int   limit[N];
  logic en[N];
  logic lastat[N];
  int   n_store;
  int   stall_left;
  logic rst_req;

  function automatic logic [7:0] word_of(input int src, input int s);
    return {2'(src), 1'b1, 5'(s)};
  endfunction

  task automatic push_words(input int src, input int from, input int cnt);
    for (int k = 0; k < cnt; k++) sb.push_back('{data: word_of(src, from + k), hdr: 1'b0, src: src});
  endtask

  task automatic push_hdr(input int src);
    if (H == 1) sb.push_back('{data: 8'(src), hdr: 1'b1, src: src});
  endtask

  task automatic clear_model();
    for (int i = 0; i < N; i++) begin
      seq[i] = 0; limit[i] = 0; en[i] = 1'b0; lastat[i] = 1'b0;
    end
    sb.delete();
    n_store = 0; stall_left = 0; rst_req = 1'b0;
  endtask

  // One model-driven cycle: drive at negedge, inspect outputs 1 ns later.
  task automatic step();
    sb_t it;
    @(negedge wclk);
    wreset   = rst_req;
    bus.wfull = (stall_left > 0) || rst_req;
    if (stall_left > 0) stall_left--;
    for (int i = 0; i < N; i++) begin
      bus.req[i]               = en[i] && (seq[i] < limit[i]);
      bus.reqlast[i]           = lastat[i] && (seq[i] == limit[i] - 1);
      bus.reqdata[i*WIDTH +: WIDTH] = word_of(i, seq[i]);
    end
    #1;
    if (bus.wfull) begin
      check("wstore_while_full", {31'd0, bus.wstore}, 32'd0);
      check("ack_while_full", {28'd0, bus.ack}, 32'd0);
    end
    if (bus.wstore) begin
      n_store++;
      if (sb.size() == 0) begin
        check("sb_unexpected_store", {24'd0, bus.wdata}, 32'hFFFF_FFFF);
      end else begin
        it = sb.pop_front();
        check("sb_wdata", {24'd0, bus.wdata}, {24'd0, it.data});
        check("sb_ack", {28'd0, bus.ack}, it.hdr ? 32'd0 : (32'd1 << it.src));
      end
    end else begin
      check("ack_without_store", {28'd0, bus.ack}, 32'd0);
    end
    for (int i = 0; i < N; i++) if (bus.ack[i]) seq[i]++;
  endtask

  task automatic run_until(input int target, input int budget, input string nm);
    for (int c = 0; c < budget && n_store < target; c++) step();
    check(nm, n_store, target);
  endtask

  task automatic reset_dut();
    @(negedge wclk);
    wreset = 1'b1;
    bus.req = '0; bus.reqlast = '0; bus.wfull = 1'b0; bus.reqdata = '0;
    @(negedge wclk);
    wreset = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_wstore", {31'd0, bus.wstore}, 32'd0);
    check("rst_ack", {28'd0, bus.ack}, 32'd0);
    check("rst_owner", {30'd0, owner}, 32'd0);
    clear_model();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [3:0] req;
    logic [3:0] last;
    logic       wfull;
    logic       ws;
    logic [3:0] ack;
    logic       busy;
    logic [1:0] own;
  } vec_t;
  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] r, input logic [3:0] l, input logic f,
                              input logic ws, input logic [3:0] a, input logic b, input logic [1:0] o);
    vec_t v;
    v.req = r; v.last = l; v.wfull = f; v.ws = ws; v.ack = a; v.busy = b; v.own = o;
    return v;
  endfunction

  initial begin
    int tot;
    logic stalled;
    wreset = 1'b0;
    bus.req = '0; bus.reqlast = '0; bus.wfull = 1'b0; bus.reqdata = '0;
    clear_model();

    //         req    last   wf    ws    ack    busy  own
    vecs.push_back(mk(4'h1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0)); // arbitration bubble
    vecs.push_back(mk(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(4'h1, 4'h0, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(4'h1, 4'h1, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0)); // round robin 1,2,3,0
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'h8, 1'b1, 2'd3));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b0, 4'h0, 1'b0, 2'd3));
    vecs.push_back(mk(4'hF, 4'hF, 1'b0, 1'b1, 4'h1, 1'b1, 2'd0));
    vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd0)); // wfull stall
    vecs.push_back(mk(4'h2, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 2'd1));
    vecs.push_back(mk(4'h2, 4'h2, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1));
    vecs.push_back(mk(4'h4, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1)); // owner drops req
    vecs.push_back(mk(4'h4, 4'h0, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 2'd2));
    vecs.push_back(mk(4'h6, 4'h4, 1'b0, 1'b1, 4'h4, 1'b1, 2'd2));
    vecs.push_back(mk(4'h2, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd2));
    vecs.push_back(mk(4'h2, 4'h2, 1'b0, 1'b1, 4'h2, 1'b1, 2'd1));
    vecs.push_back(mk(4'h0, 4'h0, 1'b0, 1'b0, 4'h0, 1'b0, 2'd1));

    reset_dut();
`ifndef AFIFO_ARB_HDR_EN
    for (int v = 0; v < vecs.size(); v++) begin
      @(negedge wclk);
      bus.req = vecs[v].req; bus.reqlast = vecs[v].last; bus.wfull = vecs[v].wfull;
      bus.reqdata = {8'h44, 8'h33, 8'h22, 8'h11};
      #1;
      check($sformatf("vec%0d_wstore", v), {31'd0, bus.wstore}, {31'd0, vecs[v].ws});
      check($sformatf("vec%0d_ack", v), {28'd0, bus.ack}, {28'd0, vecs[v].ack});
      check($sformatf("vec%0d_busy", v), {31'd0, busy}, {31'd0, vecs[v].busy});
      check($sformatf("vec%0d_owner", v), {30'd0, owner}, {30'd0, vecs[v].own});
      if (vecs[v].ws)
        check($sformatf("vec%0d_wdata", v), {24'd0, bus.wdata}, 32'h11 * (vecs[v].own + 1));
    end
`endif

    // MAXBURST split, single-requester re-grant, then hand-over to requester 0
    reset_dut();
    en[2] = 1'b1; limit[2] = 32;
    push_hdr(2); push_words(2, 0, 16);
    push_hdr(2); push_words(2, 16, 16);
    push_hdr(0); push_words(0, 0, 4);
    tot = sb.size();
    run_until(16 + H, 200, "maxburst_first");
    step();
    check("maxburst_gap_busy", {31'd0, busy}, 32'd0);
    check("maxburst_gap_wstore", {31'd0, bus.wstore}, 32'd0);
    step();
    check("regrant_busy", {31'd0, busy}, 32'd1);
    check("regrant_owner", {30'd0, owner}, 32'd2);
    en[0] = 1'b1; limit[0] = 4; lastat[0] = 1'b1;
    run_until(tot, 300, "maxburst_all");
    check("maxburst_sb_empty", sb.size(), 0);
    check("maxburst_seq2", seq[2], 32);
    check("maxburst_seq0", seq[0], 4);

    // Five-cycle wfull stall in the middle of a burst
    reset_dut();
    en[1] = 1'b1; limit[1] = 6; lastat[1] = 1'b1;
    push_hdr(1); push_words(1, 0, 6);
    tot = sb.size();
    stalled = 1'b0;
    for (int c = 0; c < 100 && n_store < tot; c++) begin
      if (!stalled && n_store == H + 2) begin
        stall_left = 5;
        stalled = 1'b1;
      end
      step();
    end
    check("stall_stores", n_store, tot);
    check("stall_happened", {31'd0, stalled}, 32'd1);
    check("stall_sb_empty", sb.size(), 0);
    step();
    check("stall_end_busy", {31'd0, busy}, 32'd0);

    // Reset in the middle of a burst of requester 3
    reset_dut();
    en[3] = 1'b1; limit[3] = 6; lastat[3] = 1'b1;
    push_hdr(3); push_words(3, 0, 3);
    run_until(H + 3, 100, "prereset_stores");
    rst_req = 1'b1;
    step();
    rst_req = 1'b0;
    en[0] = 1'b1; limit[0] = 2; lastat[0] = 1'b1;
    push_hdr(0); push_words(0, 0, 2);
    push_hdr(3); push_words(3, 3, 3);
    tot = n_store + sb.size();
    step();
    check("postreset_busy", {31'd0, busy}, 32'd0);
    check("postreset_wstore", {31'd0, bus.wstore}, 32'd0);
    check("postreset_owner", {30'd0, owner}, 32'd0);
    step();
    check("postreset_grant_busy", {31'd0, busy}, 32'd1);
    check("postreset_grant_owner", {30'd0, owner}, 32'd0);
    run_until(tot, 100, "postreset_stores");
    check("postreset_sb_empty", sb.size(), 0);
    check("postreset_seq3", seq[3], 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
